// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: Set-2 scan-code parser with repeat filter and FWFT event FIFO
//   clk, reset (async, active-low), rx_done_tick/dout: received byte strobe and data,
//   rd_en: pop head entry, key_code/key_ext/key_break: head entry,
//   empty/full: FIFO status, overflow: sticky drop flag cleared by a pop
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPORT_MODE   = 0,
    parameter int FILTER_REPEAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] dout,
    input  logic       rd_en,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       empty,
    output logic       full,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
    state_t        state;
    logic [2:0]    skip_cnt;
    logic          held_valid, held_ext;
    logic [7:0]    held_code;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, nxt_rd;
    logic [AW:0]   count, nxt_cnt;
    logic          ev_valid, ev_ext, ev_brk, held_match, suppress, type_en, push, pop, wr_ok;
    logic [9:0]    new_entry, head_nxt;
    always_comb begin
        ev_valid = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        if (rx_done_tick)
            case (state)
                IDLE:    ev_valid = !(dout inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF});
                EXT:     begin ev_valid = !(dout inside {8'hF0, 8'hE0, 8'h12, 8'h59}); ev_ext = 1'b1; end
                BRK:     begin ev_valid = 1'b1; ev_brk = 1'b1; end
                EXT_BRK: begin ev_valid = !(dout inside {8'h12, 8'h59}); ev_ext = 1'b1; ev_brk = 1'b1; end
                default: ;
            endcase
    end
    assign held_match = held_valid && held_ext == ev_ext && held_code == dout;
    assign suppress   = FILTER_REPEAT != 0 && !ev_brk && held_match;
    assign type_en    = ev_brk ? REPORT_MODE != 1 : REPORT_MODE != 0;
    assign push       = ev_valid && !suppress && type_en;
    assign pop        = rd_en && !empty;
    assign wr_ok      = push && (!full || pop);
    assign new_entry  = {ev_ext, ev_brk, dout};
    assign nxt_rd     = rd_ptr + AW'(pop);
    assign nxt_cnt    = count + (AW+1)'(wr_ok) - (AW+1)'(pop);
    // The only time the new head is the entry being written is when the FIFO would otherwise be empty.
    assign head_nxt   = (wr_ok && wr_ptr == nxt_rd) ? new_entry : mem[nxt_rd];
    assign empty      = count == '0;
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
        end else if (rx_done_tick) begin
            case (state)
                IDLE: begin
                    if (dout == 8'hE0) state <= EXT;
                    else if (dout == 8'hF0) state <= BRK;
                    else if (dout == 8'hE1) begin
                        state    <= SKIP;
                        skip_cnt <= 3'd7;
                    end
                end
                EXT:          state <= dout == 8'hF0 ? EXT_BRK : dout == 8'hE0 ? EXT : IDLE;
                SKIP: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state <= IDLE;
                end
                default:      state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
        end else if (FILTER_REPEAT != 0 && ev_valid) begin
            if (!ev_brk && !held_match) begin
                held_valid <= 1'b1;
                held_ext   <= ev_ext;
                held_code  <= dout;
            end else if (ev_brk && held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr   <= nxt_rd;
            count    <= nxt_cnt;
            overflow <= pop ? 1'b0 : (push && full) ? 1'b1 : overflow;
            if (nxt_cnt != '0) {key_ext, key_break, key_code} <= head_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder: checks four decoder configurations against a sequence-level reference model
module tb_ps2_key_event_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b0;
    logic [7:0] dout = 8'h00;
    logic [3:0] rd_en = 4'h0;
    logic [7:0] kc [4];
    logic       ke [4], kb [4], em [4], fu [4], ov [4];
    int total = 0;
    int bad = 0;
    // Instances: 0 = break only, 1 = make only, 2 = both, 3 = both without repeat filter
    int mode [4] = '{0, 1, 2, 2};
    int filt [4] = '{1, 1, 1, 0};
    logic [7:0] pend [$];
    logic [9:0] mq [4][$];
    bit         hv [4], he [4], movf [4];
    logic [7:0] hc [4];
    logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA, 8'h1C, 8'h75, 8'h5A, 8'h29};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ps2_key_event_decoder #(
            .FIFO_DEPTH(4),
            .REPORT_MODE(g == 0 ? 0 : g == 1 ? 1 : 2),
            .FILTER_REPEAT(g == 3 ? 0 : 1)
        ) u_dut (
            .clk(clk), .reset(reset), .rx_done_tick(rx), .dout(dout), .rd_en(rd_en[g]),
            .key_code(kc[g]), .key_ext(ke[g]), .key_break(kb[g]),
            .empty(em[g]), .full(fu[g]), .overflow(ov[g])
        );
    end

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    // Reference model: whole-sequence interpretation of the byte stream, then filter, gating and queue.
    task automatic model_step(input bit r, input logic [7:0] b, input logic [3:0] m);
        bit done = 0, ext = 0, brk = 0, disc = 0;
        logic [7:0] code = 8'h00;
        int n = 0;
        for (int i = 0; i < 4; i++)
            if (m[i] && mq[i].size() > 0) begin
                void'(mq[i].pop_front());
                movf[i] = 0;
            end
        if (!r) return;
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (pend.size() == 8) pend.delete();
            return;
        end
        while (n < pend.size() && pend[n] == 8'hE0) n++;
        ext = n > 0;
        if (n < pend.size()) begin
            if (pend[n] != 8'hF0) begin
                code = pend[n];
                done = 1;
            end else if (n + 1 < pend.size()) begin
                code = pend[n+1];
                brk = 1;
                done = 1;
            end
        end
        if (!done) return;
        pend.delete();
        disc = (ext && (code == 8'h12 || code == 8'h59)) ||
               (!ext && !brk && code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF});
        if (disc) return;
        for (int i = 0; i < 4; i++) begin
            bit match = hv[i] && he[i] == ext && hc[i] == code;
            bit sup = 0;
            if (filt[i] != 0) begin
                if (!brk) begin
                    if (match) sup = 1;
                    else begin hv[i] = 1; he[i] = ext; hc[i] = code; end
                end else if (match) hv[i] = 0;
            end
            if (!sup && (brk ? mode[i] != 1 : mode[i] != 0)) begin
                if (mq[i].size() < 4) mq[i].push_back({ext, brk, code});
                else movf[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("empty", i, em[i], mq[i].size() == 0);
            chk("full", i, fu[i], mq[i].size() == 4);
            chk("overflow", i, ov[i], movf[i]);
            if (mq[i].size() > 0) chk("head", i, {ke[i], kb[i], kc[i]}, mq[i][0]);
        end
    endtask

    task automatic step(input bit r, input logic [7:0] b, input logic [3:0] m);
        rx = r;
        dout = b;
        rd_en = m;
        @(posedge clk);
        model_step(r, b, m);
        #1;
        rx = 1'b0;
        rd_en = 4'h0;
        check_all();
    endtask

    task automatic sendb(input logic [7:0] b);
        step(1'b1, b, 4'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        pend.delete();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            movf[i] = 0;
            hv[i] = 0;
            chk("rst_empty", i, em[i], 1'b1);
            chk("rst_full", i, fu[i], 1'b0);
            chk("rst_ovf", i, ov[i], 1'b0);
            chk("rst_head", i, {ke[i], kb[i], kc[i]}, 10'h000);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] codes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        // Break-only default: one release of 1C
        do_reset();
        sendb(8'h1C); sendb(8'hF0); sendb(8'h1C);
        chk("t1_head", 0, {em[0], ke[0], kb[0], kc[0]}, 11'h11C);
        step(1'b0, 8'h00, 4'hF);
        chk("t1_popped", 0, em[0], 1'b1);
        // Typematic repeats of an extended key
        do_reset();
        for (int k = 0; k < 3; k++) begin sendb(8'hE0); sendb(8'h75); end
        sendb(8'hE0); sendb(8'hF0); sendb(8'h75);
        chk("t2_first", 2, {ke[2], kb[2], kc[2]}, 10'h275);
        step(1'b0, 8'h00, 4'b0100);
        chk("t2_second", 2, {ke[2], kb[2], kc[2]}, 10'h375);
        step(1'b0, 8'h00, 4'b0100);
        chk("t2_drained", 2, em[2], 1'b1);
        // Pause sequence is swallowed
        do_reset();
        foreach (pool[k]) ;
        sendb(8'hE1); sendb(8'h14); sendb(8'h77); sendb(8'hE1);
        sendb(8'hF0); sendb(8'h14); sendb(8'hF0); sendb(8'h77);
        chk("t3_none", 0, em[0], 1'b1);
        sendb(8'hF0); sendb(8'h29);
        chk("t3_head", 0, {em[0], ke[0], kb[0], kc[0]}, 11'h129);
        // Overflow on the fifth release, then in-order drain
        do_reset();
        for (int k = 0; k < 5; k++) begin sendb(8'hF0); sendb(codes[k]); end
        chk("t4_full", 0, fu[0], 1'b1);
        chk("t4_ovf", 0, ov[0], 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_order", 0, {em[0], ke[0], kb[0], kc[0]}, {3'b001, codes[k]});
            step(1'b0, 8'h00, 4'b0001);
        end
        chk("t4_empty", 0, em[0], 1'b1);
        // Fifth push coincides with a pop
        do_reset();
        for (int k = 0; k < 4; k++) begin sendb(8'hF0); sendb(codes[k]); end
        sendb(8'hF0);
        step(1'b1, codes[4], 4'b0001);
        chk("t5_ovf", 0, ov[0], 1'b0);
        chk("t5_full", 0, fu[0], 1'b1);
        chk("t5_head", 0, {ke[0], kb[0], kc[0]}, {2'b01, codes[1]});
        // Status bytes and fake shift leave the FSM idle
        do_reset();
        sendb(8'hAA); sendb(8'hFA); sendb(8'hEE); sendb(8'hE0); sendb(8'h12);
        for (int i = 0; i < 4; i++) chk("t6_none", i, em[i], 1'b1);
        sendb(8'hF0); sendb(8'h1C);
        chk("t6_head", 0, {em[0], ke[0], kb[0], kc[0]}, 11'h11C);
        // Reset in the middle of E0 F0
        do_reset();
        sendb(8'hE0); sendb(8'hF0);
        do_reset();
        sendb(8'h5A);
        chk("t7_head", 1, {em[1], ke[1], kb[1], kc[1]}, 11'h05A);
        // Randomised traffic, including back-to-back strobes and occasional resets
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] b;
            logic [3:0] m;
            b = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 9)] : 8'($urandom);
            for (int i = 0; i < 4; i++) m[i] = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 499) == 0) do_reset();
            else step($urandom_range(0, 3) != 0, b, m);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_event_decoder.md
# ps2_key_event_decoder

Parametrised PS/2 scan-code decoder for the keyboard path. It sits between the PS/2 receiver, which supplies `dout`/`rx_done_tick`, and the key-consuming logic. It parses Set-2 make, break (`F0`) and extended (`E0`) sequences, and discards the Pause (`E1`) sequence and keyboard status bytes. Completed key events are queued in a first-word-fall-through FIFO that the consumer pops. Compared with the plain break-code flag generator, it adds extended-key support, selectable make/break reporting, repeat filtering and buffering.

## Interface
- `FIFO_DEPTH`, default 4: number of event entries; power of two, ≥2.
- `REPORT_MODE`, default 0: 0 = break events only, 1 = make events only, 2 = both.
- `FILTER_REPEAT`, default 1: 1 = suppress typematic repeats of a held key; 0 = report every make.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `rx_done_tick` input 1: one-cycle strobe; `dout` is valid in the same cycle.
- `dout` input 8: received scan byte.
- `rd_en` input 1: pops the head entry; ignored when `empty`=1.
- `key_code` output 8: head entry code byte (`E0`/`F0` prefixes stripped).
- `key_ext` output 1: head entry was `E0`-prefixed.
- `key_break` output 1: head entry is a release (1) or a press (0).
- `empty` output 1: FIFO holds no entries.
- `full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full. Cleared only by a `rd_en` pop or by reset.

## Operation
- Bytes are examined only when `rx_done_tick`=1. Any other cycle leaves the FSM, the filter and the FIFO write side unchanged.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE:
  - `E0` → EXT.
  - `F0` → BRK.
  - `E1` → SKIP and load the skip counter with 7.
  - `AA`, `FA`, `EE`, `FE`, `00`, `FF` → discarded, stay in IDLE.
  - Any other byte completes a make event {ext=0, brk=0} and stays in IDLE.
- EXT:
  - `F0` → EXT_BRK.
  - `E0` → stay in EXT.
  - `12` or `59` (fake shifts) → discarded, go to IDLE.
  - Any other byte completes a make event {ext=1, brk=0} and goes to IDLE.
- BRK: any byte completes a break event {ext=0, brk=1} and goes to IDLE.
- EXT_BRK:
  - `12` or `59` → discarded, go to IDLE.
  - Any other byte completes a break event {ext=1, brk=1} and goes to IDLE.
- SKIP: each byte decrements the 3-bit counter. The byte that takes the counter from 1 to 0 returns the FSM to IDLE. No events are generated in SKIP.
- Repeat filter (`FILTER_REPEAT`=1):
  - Register `held` = {valid, ext, code}.
  - A make event is suppressed when it matches a valid `held`. Otherwise it loads `held` and is eligible for report.
  - A break event that matches `held` clears `held.valid`.
  - Break events are never suppressed by the filter.
- Report gating: a non-suppressed event is pushed only if its type is enabled by `REPORT_MODE`. The filter updates regardless of `REPORT_MODE`.
- FIFO:
  - Entry is 10 bits: {ext, brk, code}.
  - Write and read pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth; an occupancy counter is log2(`FIFO_DEPTH`)+1 bits.
  - Push while full with no pop: the event is dropped, contents are unchanged, `overflow` is set.
  - Push and pop in the same cycle while full: both are performed; occupancy is unchanged; `overflow` is not set.
  - Push and pop in the same cycle while empty: push only.
  - Outputs always show the head entry. When empty they hold the last value and must not be used.

## Timing
- Reset values:
  - FSM = IDLE, skip counter = 0, `held.valid` = 0.
  - Pointers and occupancy = 0.
  - `empty`=1, `full`=0, `overflow`=0.
  - `key_code`=8'h00, `key_ext`=0, `key_break`=0.
- Latency: the event is pushed at the `clk` edge that samples `rx_done_tick` with the final byte. `empty` falls and the outputs show the entry one cycle after the strobe.
- Pop: with `rd_en`=1 at edge N, the next entry (or `empty`=1) is visible after edge N.
- Reset asserted mid-sequence (for example after `E0 F0`) aborts the sequence. Bytes that follow are parsed from IDLE.
- Back-to-back `rx_done_tick` on consecutive cycles is supported; one byte is processed per cycle.

## Test plan
- Reset, then defaults (`REPORT_MODE`=0): `1C F0 1C` → exactly one entry {code 1C, ext 0, brk 1}, `empty` falls 1 cycle after the last strobe; `rd_en` → `empty`=1.
- `REPORT_MODE`=2, `FILTER_REPEAT`=1: `E0 75 E0 75 E0 75 E0 F0 75` → two entries: {75, ext 1, brk 0} then {75, ext 1, brk 1}.
- Pause sequence `E1 14 77 E1 F0 14 F0 77`, then `F0 29` → only {29, ext 0, brk 1} is queued.
- `FIFO_DEPTH`=4, five break events with no reads → `full`=1, `overflow`=1, and the first four codes pop in order. Repeat with a pop on the same cycle as the 5th push → no overflow and four entries remain.
- Status bytes `AA FA EE` and fake shift `E0 12` → no entries; the FSM is in IDLE afterwards (verified by `F0 1C` → one entry).
- Assert `reset` after `E0 F0`, release, send `5A` → with `REPORT_MODE`=1, one entry {5A, ext 0, brk 0}.
